// File: rtl/inter_layer_buffer_pkg.sv
// inter_layer_pkg: shared types and derived constants for inter_layer_buffer.
//   ilb_state_e   : buffer FSM states (IDLE / FILL / READY / PLAY)
//   ILB_*         : default geometry (256-bit words, 16-bit samples, 64 words)
//   LANES, ADDR_W : constants derived from the default geometry
//   ilb_lanes()   : samples per packed word for a given geometry
//   ilb_addr_w()  : RAM address width for a given depth (min 1 bit)
package inter_layer_pkg;

  localparam int ILB_DATA_WIDTH = 256;
  localparam int ILB_LANE_WIDTH = 16;
  localparam int ILB_DEPTH      = 64;

  localparam int LANES  = ILB_DATA_WIDTH / ILB_LANE_WIDTH;
  localparam int ADDR_W = $clog2(ILB_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_PLAY  = 2'd3
  } ilb_state_e;

  function automatic int ilb_lanes(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  function automatic int ilb_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inter_layer_buffer_if.sv
// inter_layer_buffer_if: all stream, replay and status signals of the buffer.
//   s_t*        : activation sample stream into the buffer
//   start       : replay request pulse
//   m_t*        : packed word burst out (no backpressure)
//   word_count, busy, err_overflow, err_start : status
// Modports: slave = buffer side, master = producer/consumer/controller side.
interface inter_layer_buffer_if
  import inter_layer_pkg::*;
#(
  parameter int DATA_WIDTH = ILB_DATA_WIDTH,
  parameter int LANE_WIDTH = ILB_LANE_WIDTH,
  parameter int DEPTH      = ILB_DEPTH
) ();

  logic [LANE_WIDTH-1:0]          s_tdata;
  logic                           s_tvalid;
  logic                           s_tlast;
  logic                           s_tready;
  logic                           start;
  logic [DATA_WIDTH-1:0]          m_tdata;
  logic                           m_tvalid;
  logic                           m_tlast;
  logic [$clog2(DEPTH+1)-1:0]     word_count;
  logic                           busy;
  logic                           err_overflow;
  logic                           err_start;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, start,
    output s_tready, m_tdata, m_tvalid, m_tlast,
           word_count, busy, err_overflow, err_start
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, start,
    input  s_tready, m_tdata, m_tvalid, m_tlast,
           word_count, busy, err_overflow, err_start
  );

endinterface

// File: rtl/inter_layer_buffer_ram.sv
// ilb_sdp_ram: simple dual-port RAM, one write and one read port,
// DEPTH x DATA_WIDTH, one-cycle registered read. Storage is not reset.
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i         : read request
//   rdata_o              : read data, valid the cycle after re_i
module ilb_sdp_ram #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inter_layer_buffer.sv
// inter_layer_buffer: packs a layer's activation stream into DATA_WIDTH
// words, stores them in RAM and replays the vector as a valid/last burst on
// each start pulse while READY.
//   clk, rst_n : clock, async active-low reset
//   bus        : inter_layer_buffer_if.slave (stream in, burst out, status)
module inter_layer_buffer
  import inter_layer_pkg::*;
#(
  parameter int DATA_WIDTH = ILB_DATA_WIDTH,
  parameter int LANE_WIDTH = ILB_LANE_WIDTH,
  parameter int DEPTH      = ILB_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inter_layer_buffer_if.slave  bus
);

  localparam int NLANE  = ilb_lanes(DATA_WIDTH, LANE_WIDTH);
  localparam int AW     = ilb_addr_w(DEPTH);
  localparam int WC_W   = $clog2(DEPTH+1);
  localparam int LANE_W = (NLANE > 1) ? $clog2(NLANE) : 1;
  localparam int STAGES = 2;  // RAM read + output register

  localparam logic [WC_W-1:0]   DEPTH_C   = WC_W'(DEPTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NLANE-1);

  ilb_state_e                             state_q;
  logic                                   rdy_q;
  logic [LANE_W-1:0]                      lane_q;
  logic [NLANE-1:0][LANE_WIDTH-1:0]       pack_q, pack_d;
  logic [WC_W-1:0]                        wcnt_q, wcnt_d;
  logic [WC_W-1:0]                        word_count_q;
  logic [WC_W-1:0]                        raddr_q;
  logic                                   rd_done_q;
  logic                                   err_ovf_q, err_start_q;
  logic [STAGES:1]                        vld_pipe_q, last_pipe_q;
  logic [DATA_WIDTH-1:0]                  m_tdata_q;
  logic [DATA_WIDTH-1:0]                  rdata;

  logic accept, ovf, word_done, rd_en, rd_last;

  // rdy_q holds s_tready low while reset is asserted and for the release edge.
  // A start in READY steals the cycle from the stream.
  assign bus.s_tready = rdy_q & ((state_q == ST_IDLE) | (state_q == ST_FILL) |
                                 ((state_q == ST_READY) & ~bus.start));
  assign accept    = bus.s_tvalid & bus.s_tready;
  assign ovf       = (wcnt_q == DEPTH_C);
  assign word_done = accept & ~ovf & ((lane_q == LAST_LANE) | bus.s_tlast);
  assign wcnt_d    = wcnt_q + WC_W'(word_done);

  always_comb begin
    pack_d         = pack_q;
    pack_d[lane_q] = bus.s_tdata;
  end

  assign rd_en   = (state_q == ST_PLAY) & ~rd_done_q;
  assign rd_last = (raddr_q == word_count_q - WC_W'(1));

  // Completed words are written at the edge that accepts their final lane,
  // so the tlast word is in RAM by the time READY is visible.
  ilb_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (word_done),
    .waddr_i (wcnt_q[AW-1:0]),
    .wdata_i (pack_d),
    .re_i    (rd_en),
    .raddr_i (raddr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  // FSM, packer and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rdy_q        <= 1'b0;
      lane_q       <= '0;
      pack_q       <= '0;
      wcnt_q       <= '0;
      word_count_q <= '0;
      raddr_q      <= '0;
      rd_done_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_start_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (bus.start && state_q != ST_READY) err_start_q <= 1'b1;
      if (accept && ovf) err_ovf_q <= 1'b1;

      if (accept) begin
        if (!ovf) begin
          if (word_done) begin
            pack_q <= '0;
            lane_q <= '0;
            wcnt_q <= wcnt_d;
          end else begin
            pack_q <= pack_d;
            lane_q <= lane_q + LANE_W'(1);
          end
        end
        if (bus.s_tlast) begin
          word_count_q <= wcnt_d;
          wcnt_q       <= '0;
          lane_q       <= '0;
          pack_q       <= '0;
          state_q      <= ST_READY;
        end else begin
          state_q      <= ST_FILL;
        end
      end else begin
        case (state_q)
          ST_READY: if (bus.start) begin
            state_q   <= ST_PLAY;
            raddr_q   <= '0;
            rd_done_q <= 1'b0;
          end
          ST_PLAY: begin
            if (rd_en) begin
              raddr_q <= raddr_q + WC_W'(1);
              if (rd_last) rd_done_q <= 1'b1;
            end
            // leave PLAY as the final word is registered onto m_*
            if (last_pipe_q[1]) state_q <= ST_READY;
          end
          default: ;
        endcase
      end
    end
  end

  // Replay pipeline: stage 1 = RAM output, stage 2 = m_* registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      m_tdata_q   <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[1], rd_en};
      last_pipe_q <= {last_pipe_q[1], rd_en & rd_last};
      m_tdata_q   <= vld_pipe_q[1] ? rdata : '0;
    end
  end

  assign bus.m_tdata      = m_tdata_q;
  assign bus.m_tvalid     = vld_pipe_q[STAGES];
  assign bus.m_tlast      = last_pipe_q[STAGES];
  assign bus.word_count   = word_count_q;
  assign bus.busy         = (state_q == ST_FILL) | (state_q == ST_PLAY);
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_start    = err_start_q;

endmodule

// File: tb/tb_inter_layer_buffer.sv
module tb_inter_layer_buffer;

  localparam int DW = 256;
  localparam int LW = 16;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] q_data [$];
  bit            q_last [$];
  int            q_cyc  [$];

  inter_layer_buffer_if #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .DEPTH(DP)) bus ();

  inter_layer_buffer #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.m_tvalid === 1'b1) begin
      q_data.push_back(bus.m_tdata);
      q_last.push_back(bus.m_tlast);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] expw(input int base, input int n, input int w);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      if (16*w + j < n) r[16*j +: 16] = 16'(base + 16*w + j);
    return r;
  endfunction

  task automatic clrq();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic send(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.s_tdata  = 16'(base + i);
      bus.s_tvalid = 1'b1;
      bus.s_tlast  = (i == n-1);
      tick();
      if (i == 0 && n > 1) chk("fill_busy", bus.busy, 1);
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  // nw words expected, built from base/n; extra_at >= 0 pulses start again
  // mid-burst; beat presents a sample in the start cycle.
  task automatic play(input string tag, input int nw, input int base, input int n,
                      input int extra_at, input bit beat);
    int sn;
    int waited;
    clrq();
    bus.start = 1'b1;
    if (beat) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = 16'hBEEF;
      #1;
      chk({tag, "_tready_lo"}, bus.s_tready, 0);
    end
    tick();
    sn = cyc;
    bus.start    = 1'b0;
    bus.s_tvalid = 1'b0;
    waited = 0;
    while (!(q_last.size() > 0 && q_last[q_last.size()-1]) && waited < 40) begin
      if (waited == extra_at) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      waited++;
    end
    chk({tag, "_done"}, (waited < 40), 1);
    repeat (3) tick();
    chk({tag, "_nwords"}, q_data.size(), nw);
    for (int i = 0; i < nw && i < q_data.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), q_data[i], expw(base, n, i));
      chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == nw-1));
    end
    if (q_cyc.size() > 0) chk({tag, "_lat"}, q_cyc[0] - sn, 2);
    if (q_cyc.size() >= nw) chk({tag, "_b2b"}, q_cyc[nw-1] - q_cyc[0], nw-1);
    chk({tag, "_busy_after"}, bus.busy, 0);
  endtask

  initial begin
    int nlast;
    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.start    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", bus.s_tready, 0);
    chk("rst_mvalid", bus.m_tvalid, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_tready_rel", bus.s_tready, 1);
    chk("rst_mdata", bus.m_tdata, 0);
    chk("rst_mlast", bus.m_tlast, 0);
    chk("rst_wc", bus.word_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_eovf", bus.err_overflow, 0);
    chk("rst_estart", bus.err_start, 0);

    // 32 samples -> 2 full words
    send(32, 0);
    chk("v32_wc", bus.word_count, 2);
    chk("v32_busy", bus.busy, 0);
    play("v32", 2, 0, 32, -1, 1'b0);
    chk("v32_estart", bus.err_start, 0);

    // 20 samples -> second word partial, zero padded; replay twice
    send(20, 0);
    chk("v20_wc", bus.word_count, 2);
    play("v20a", 2, 0, 20, -1, 1'b0);
    play("v20b", 2, 0, 20, -1, 1'b0);

    // start during PLAY ignored, burst undisturbed
    play("pstart", 2, 0, 20, 1, 1'b0);
    chk("pstart_err", bus.err_start, 1);

    // start and sample together in READY: start wins
    play("same", 2, 0, 20, -1, 1'b1);
    chk("same_wc", bus.word_count, 2);

    // overflow: 70 samples into 4 words
    chk("ovf_pre", bus.err_overflow, 0);
    send(70, 'h1000);
    chk("ovf_err", bus.err_overflow, 1);
    chk("ovf_wc", bus.word_count, 4);
    play("ovf", 4, 'h1000, 64, -1, 1'b0);

    // reset during word 1 of a 4-word burst
    clrq();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("mid_vld", bus.m_tvalid, 1);
    chk("mid_word1", bus.m_tdata, expw('h1000, 64, 1));
    rst_n = 1'b0;
    #1;
    chk("arst_vld", bus.m_tvalid, 0);
    chk("arst_data", bus.m_tdata, 0);
    chk("arst_last", bus.m_tlast, 0);
    chk("arst_tready", bus.s_tready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) tick();
    nlast = 0;
    foreach (q_last[i]) if (q_last[i]) nlast++;
    chk("abandon_nolast", nlast, 0);
    chk("abandon_words", q_data.size(), 1);
    chk("post_wc", bus.word_count, 0);
    chk("post_busy", bus.busy, 0);
    chk("post_tready", bus.s_tready, 1);
    chk("post_eovf", bus.err_overflow, 0);
    chk("post_estart", bus.err_start, 0);

    // start in IDLE: no output, error flagged
    clrq();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("idle_nout", q_data.size(), 0);
    chk("idle_estart", bus.err_start, 1);
    chk("idle_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
